// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared state encoding and constants for the LFSR keystream generator.
package lfsr_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ks_state_e;
  localparam logic [15:0] LFSR_DEFAULT_TAPS = 16'hB400;
  localparam int BYTE_BITS = 8;
endpackage

// File: rtl/ks_byte_pack.sv
// ks_byte_pack: packs serial keystream bits MSB-first into bytes behind a valid/ready handshake.
module ks_byte_pack
  import lfsr_pkg::*;
(
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 bit_i,
  input  logic                 ready_i,
  output logic [BYTE_BITS-1:0] byte_o,
  output logic                 valid_o,
  output logic                 full_o
);
  localparam int CW = $clog2(BYTE_BITS);
  localparam logic [CW-1:0] LAST = CW'(BYTE_BITS - 1);
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BYTE_BITS-1:0] sr_q, sr_d, byte_q, byte_d, sr_shift;
  logic                 valid_q, valid_d;
  assign sr_shift = {sr_q[BYTE_BITS-2:0], bit_i};
  assign full_o   = step_i && (cnt_q == LAST);
  assign byte_o   = byte_q;
  assign valid_o  = valid_q;
  // A reload discards any pending byte but leaves the last byte value in place.
  always_comb begin
    cnt_d   = load_i ? '0 : step_i ? cnt_q + 1'b1 : cnt_q;
    sr_d    = load_i ? '0 : step_i ? sr_shift : sr_q;
    byte_d  = (!load_i && full_o) ? sr_shift : byte_q;
    valid_d = load_i ? 1'b0 : full_o ? 1'b1 : (valid_q && ready_i) ? 1'b0 : valid_q;
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q   <= '0;
      sr_q    <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/lfsr_keystream.sv
// lfsr_keystream: seeded Fibonacci LFSR keystream byte generator with valid/ready output.
// Define LFSR_ZERO_GUARD_EN to load an all-zero seed as all ones (avoids lock-up).
module lfsr_keystream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEFAULT_TAPS)
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 seed_valid,
  input  logic [WIDTH-1:0]     seed,
  input  logic                 enable,
  output logic [BYTE_BITS-1:0] out_byte,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);
  ks_state_e        state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, seed_load;
  logic             busy_q, step, fb, full;
`ifdef LFSR_ZERO_GUARD_EN
  assign seed_load = (seed == '0) ? '1 : seed;
`else
  assign seed_load = seed;
`endif
  assign step = (state_q == RUN) && enable && !seed_valid;
  assign fb   = ^(lfsr_q & TAPS);
  assign busy = busy_q;
  // A seed overrides everything, including a handshake completing in HOLD.
  always_comb begin
    lfsr_d  = seed_valid ? seed_load : step ? {lfsr_q[WIDTH-2:0], fb} : lfsr_q;
    state_d = seed_valid ? RUN :
              (state_q == RUN && full) ? HOLD :
              (state_q == HOLD && out_valid && out_ready) ? RUN : state_q;
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      busy_q  <= state_d != IDLE;
    end
  end
  ks_byte_pack u_pack (
    .clk     (clk),
    .clear_n (clear_n),
    .load_i  (seed_valid),
    .step_i  (step),
    .bit_i   (lfsr_q[WIDTH-1]),
    .ready_i (out_ready),
    .byte_o  (out_byte),
    .valid_o (out_valid),
    .full_o  (full)
  );
endmodule

// File: tb/tb_lfsr_keystream.sv
// tb_lfsr_keystream: scoreboard bench for lfsr_keystream (WIDTH=16, TAPS=16'hB400).
module tb_lfsr_keystream;
  logic        clk = 1'b0, clear_n = 1'b0, seed_valid = 1'b0, enable = 1'b0, out_ready = 1'b0;
  logic [15:0] seed = '0;
  logic [7:0]  out_byte;
  logic        out_valid, busy;
  logic [15:0] m_lfsr, hold_lfsr;
  logic [7:0]  exp_q[$];
  int          n_chk = 0, n_pass = 0, n = 0;
  always #5 clk = ~clk;
  lfsr_keystream #(.WIDTH(16), .TAPS(16'hB400)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .seed_valid (seed_valid),
    .seed       (seed),
    .enable     (enable),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );
  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask
  task automatic push_bytes(input int cnt);
    logic [7:0] b;
    for (int i = 0; i < cnt; i++) begin
      b = '0;
      for (int j = 0; j < 8; j++) begin
        b = {b[6:0], m_lfsr[15]};
        m_lfsr = nxt(m_lfsr);
      end
      exp_q.push_back(b);
    end
  endtask
  task automatic do_seed(input logic [15:0] s);
    seed = s;
    seed_valid = 1'b1;
    @(posedge clk); #1;
    seed_valid = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
    m_lfsr = (s == 16'h0) ? 16'hFFFF : s;
`else
    m_lfsr = s;
`endif
    exp_q.delete();
    push_bytes(3);
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) chk("valid_timeout", {31'd0, out_valid}, 1);
  endtask
  task automatic get_byte(input string tag, output int cyc);
    wait_valid(cyc);
    chk(tag, {24'd0, out_byte}, {24'd0, exp_q.pop_front()});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #12;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_byte", {24'd0, out_byte}, 0);
    @(posedge clk); #1;
    clear_n = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_valid", {31'd0, out_valid}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    do_seed(16'hACE1);
    chk("run_busy", {31'd0, busy}, 1);
    get_byte("ace1_b0", n);
    chk("ace1_b0_byte", {24'd0, out_byte}, 32'hAC);
    chk("ace1_lat", n, 8);
    @(posedge clk); #1;
    chk("ace1_one_cycle", {31'd0, out_valid}, 0);
    get_byte("ace1_b1", n);
    chk("ace1_b1_byte", {24'd0, out_byte}, 32'hE1);
    chk("ace1_gap", n + 1, 9);
    do_seed(16'h0001);
    get_byte("s1_b0", n);
    chk("s1_lat", n, 8);
    chk("s1_lfsr", {16'd0, dut.lfsr_q}, 32'h0100);
    do_seed(16'h0001);
    repeat (4) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    enable = 1'b1;
    get_byte("en_b0", n);
    chk("en_lat", n + 7, 11);
    out_ready = 1'b0;
    do_seed(16'hACE1);
    wait_valid(n);
    hold_lfsr = 16'hACE1;
    repeat (8) hold_lfsr = nxt(hold_lfsr);
    repeat (5) begin
      chk("bp_valid", {31'd0, out_valid}, 1);
      chk("bp_byte", {24'd0, out_byte}, {24'd0, exp_q[0]});
      chk("bp_lfsr", {16'd0, dut.lfsr_q}, {16'd0, hold_lfsr});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    get_byte("bp_b0", n);
    @(posedge clk); #1;
    get_byte("bp_b1", n);
    chk("bp_b1_byte", {24'd0, out_byte}, 32'hE1);
    out_ready = 1'b0;
    do_seed(16'hACE1);
    wait_valid(n);
    do_seed(16'h1234);
    chk("reseed_drop", {31'd0, out_valid}, 0);
    chk("reseed_busy", {31'd0, busy}, 1);
    out_ready = 1'b1;
    get_byte("reseed_b0", n);
    chk("reseed_b0_byte", {24'd0, out_byte}, 32'h12);
    chk("reseed_lat", n, 8);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #3;
    clear_n = 1'b0;
    #1;
    chk("clr_valid", {31'd0, out_valid}, 0);
    chk("clr_busy", {31'd0, busy}, 0);
    chk("clr_byte", {24'd0, out_byte}, 0);
    chk("clr_lfsr", {16'd0, dut.lfsr_q}, 0);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk); #1;
    do_seed(16'h0000);
    get_byte("zero_b0", n);
    @(posedge clk); #1;
    get_byte("zero_b1", n);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lfsr_keystream.md
# lfsr_keystream

Seeded Fibonacci LFSR keystream generator that packs its serial output into bytes behind a valid/ready handshake. It sits directly upstream of the `dff`/`dff_set` register stage in the crypto datapath. Each accepted byte is latched by that register stage as the keystream operand for the XOR cipher.

## Interface
Parameters:
- `WIDTH`, 16: LFSR length in bits; minimum 9.
- `TAPS`, 16'hB400: feedback mask; bit i set means state[i] is XORed into the feedback.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `clear_n`, in, 1: asynchronous active-low reset.
- `seed_valid`, in, 1: one-cycle pulse; loads `seed`.
- `seed`, in, WIDTH: new LFSR state.
- `enable`, in, 1: permits stepping while in RUN.
- `out_byte`, out, 8: completed keystream byte; MSB is the first-generated bit.
- `out_valid`, out, 1: `out_byte` is valid and held stable.
- `out_ready`, in, 1: consumer accepts `out_byte`.
- `busy`, out, 1: high in RUN or HOLD.

## Operation
- States:
  - IDLE: unseeded.
  - RUN: stepping.
  - HOLD: byte pending.
- Step:
  - out_bit = state[WIDTH-1].
  - fb = XOR-reduction of (state AND TAPS).
  - state <= {state[WIDTH-2:0], fb}.
  - shift reg <= {shift reg[6:0], out_bit}.
  - bit_cnt increments; it is 3 bits wide and wraps 7→0.
- IDLE→RUN: on `seed_valid`.
- RUN:
  - A step occurs each cycle that `enable`=1.
  - With `enable`=0, the LFSR, bit_cnt and shift reg freeze.
  - The step with bit_cnt=7 loads `out_byte` from the completed shift value, sets `out_valid`, and moves to HOLD.
- HOLD:
  - No stepping; `enable` is ignored.
  - `out_valid && out_ready` completes the handshake: `out_valid` drops at the next edge and the state returns to RUN.
- `seed_valid` has priority in every state and reloads at the next edge:
  - state <= seed.
  - bit_cnt <= 0.
  - shift reg <= 0.
  - `out_valid` <= 0; a pending byte is discarded.
  - Next state is RUN.
- `seed_valid` together with a HOLD handshake in the same cycle: the seed wins and the byte counts as dropped.
- Because the LFSR shifts left, the first two bytes after a seed equal seed[WIDTH-1:WIDTH-8] and then seed[WIDTH-9:WIDTH-16]. For WIDTH=16, these are the seed's high byte then its low byte.
- An all-zero state is a lock-up state; see Configuration.

## Timing
- Reset values:
  - state: IDLE.
  - LFSR: 0.
  - bit_cnt: 0.
  - shift reg: 0.
  - `out_byte`: 8'h00.
  - `out_valid`: 0.
  - `busy`: 0.
- Reset mid-operation takes effect immediately (asynchronous). Release is synchronous to `clk`.
- Seed at edge N: the first step can occur at edge N+1.
- With continuous `enable`, the eighth step lands at edge N+8, and `out_valid` is visible after edge N+8.
- With `out_ready` held at 1, the handshake completes at edge N+9. Stepping resumes from edge N+10.
- Sustained throughput is 1 byte per 9 cycles.
- `out_byte` is stable whenever `out_valid`=1.
- `busy` is registered and tracks the state with no added delay.

## Configuration
- `LFSR_ZERO_GUARD_EN`:
  - Defined: a seed of all zeros is loaded as all ones, so the generator never locks up.
  - Undefined: the seed is loaded verbatim. A zero seed yields a constant 8'h00 byte stream forever.

## Structure
- Package `lfsr_pkg` holds:
  - the state enum (IDLE/RUN/HOLD);
  - `LFSR_DEFAULT_TAPS` = 16'hB400;
  - `BYTE_BITS` = 8.
- One sub-module, `ks_byte_pack`, owns the shift reg, bit_cnt, `out_byte`/`out_valid` and the handshake. It takes a step strobe and a bit, and returns a `full` flag to the top FSM.

## Test plan
- Reset with `clear_n`=0, then release with no seed → `out_valid`=0 and `busy`=0 indefinitely, even with `enable`=1.
- Seed 16'hACE1, `enable`=1, `out_ready`=1:
  - first byte 8'hAC, valid after the 8th step;
  - second byte 8'hE1;
  - each byte valid for exactly 1 cycle, 9 cycles apart.
- Seed 16'h0001, `enable`=1 → first byte 8'h00 and LFSR = 16'h0100 at handshake. Toggling `enable`=0 for 3 cycles mid-byte delays `out_valid` by exactly 3 cycles.
- Backpressure, seed 16'hACE1 with `out_ready`=0 for 5 cycles → `out_valid` and `out_byte`=8'hAC held stable, no LFSR advance; the second byte is still 8'hE1.
- `seed_valid` with 16'h1234 during HOLD → `out_valid` drops next cycle, the pending byte is lost, and the next byte is 8'h12. Pulsing `clear_n` mid-byte returns all outputs to their reset values asynchronously.
- Seed 16'h0000:
  - with `LFSR_ZERO_GUARD_EN` defined → bytes 8'hFF, 8'hFF;
  - without it → 8'h00 repeated.
